// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with an internal circular return-address stack.
// The next PC is picked by priority: trap, stall, return, call, branch, then sequential.
module pc_ras_unit #(
  parameter int               WIDTH     = 64,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h100),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic             call_en_i,
  input  logic             ret_en_i,
  input  logic             trap_en_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_ovf_o,
  output logic             ras_unf_o,
  output logic             misalign_o
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_V      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d, seq_pc;
  logic [PTR_W-1:0] top_q, top_d, top_nxt, top_prv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;
  logic             push;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_top;

  assign seq_pc  = pc_q + INC_V;  // wraps modulo 2^WIDTH
  assign top_nxt = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
  assign top_prv = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);
  assign ras_top = ras_q[top_q];

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    mis_d = 1'b0;
    push  = 1'b0;
    if (trap_en_i) begin
      pc_d = TRAP_VEC;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (ret_en_i) begin
      if (cnt_q == '0) begin
        pc_d  = seq_pc;
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_top;
        top_d = top_prv;
        cnt_d = cnt_q - CNT_W'(1);
        mis_d = |(ras_top & ALIGN_MASK);
      end
    end else if (call_en_i) begin
      pc_d  = in_i;
      push  = 1'b1;
      top_d = top_nxt;
      mis_d = |(in_i & ALIGN_MASK);
      // A push into a full stack overwrites the oldest slot, which is the one after top.
      if (cnt_q == CNT_FULL) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end else if (branch_en_i) begin
      pc_d  = in_i;
      mis_d = |(in_i & ALIGN_MASK);
    end else begin
      pc_d = seq_pc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
    end
  end

  // Entry storage needs no reset: cnt_q decides which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) ras_q[top_nxt] <= seq_pc;
  end

  assign out_o       = pc_q;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == CNT_FULL);
  assign ras_ovf_o   = ovf_q;
  assign ras_unf_o   = unf_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: reset, sequencing, branch alignment, call/return stack,
// priority between controls, wrap-around and asynchronous reset.
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_en, call_en, ret_en, trap_en;
  logic [63:0] in_v, out_v;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign;
  int          tests = 0;
  int          fails = 0;

  pc_ras_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .branch_en_i(branch_en),
    .call_en_i(call_en), .ret_en_i(ret_en), .trap_en_i(trap_en), .in_i(in_v),
    .out_o(out_v), .ras_empty_o(ras_empty), .ras_full_o(ras_full),
    .ras_ovf_o(ras_ovf), .ras_unf_o(ras_unf), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; branch_en = 0; call_en = 0; ret_en = 0; trap_en = 0; in_v = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #12;
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] exp_pc;
    idle();
    rst_n = 0;
    #7;
    tests++; if (out_v !== 64'h0) begin fails++; $display("FAIL reset_out got=%h exp=0", out_v); end
    tests++; if ({ras_empty, ras_full, ras_ovf, ras_unf, misalign} !== 5'b10000) begin
      fails++; $display("FAIL reset_flags got=%b exp=10000", {ras_empty, ras_full, ras_ovf, ras_unf, misalign}); end
    @(negedge clk); rst_n = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 64'(4 * i);
      tests++; if (out_v !== exp_pc) begin fails++; $display("FAIL seq_%0d got=%h exp=%h", i, out_v, exp_pc); end
    end
    tests++; if ({ras_empty, ras_ovf, ras_unf, misalign} !== 4'b1000) begin
      fails++; $display("FAIL seq_flags got=%b exp=1000", {ras_empty, ras_ovf, ras_unf, misalign}); end
  endtask

  task automatic test_branch();
    do_reset();
    branch_en = 1; in_v = 64'hAAAAAAAA_BBBBBBB8;
    step();
    tests++; if (out_v !== 64'hAAAAAAAA_BBBBBBB8 || misalign !== 1'b0) begin
      fails++; $display("FAIL branch_load got=%h/%b exp=aaaaaaaabbbbbbb8/0", out_v, misalign); end
    idle(); step();
    tests++; if (out_v !== 64'hAAAAAAAA_BBBBBBBC) begin fails++; $display("FAIL branch_inc got=%h exp=aaaaaaaabbbbbbbc", out_v); end
    branch_en = 1; in_v = 64'hAAAAAAAA_BBBBBBB9;
    step();
    tests++; if (out_v !== 64'hAAAAAAAA_BBBBBBB9 || misalign !== 1'b1) begin
      fails++; $display("FAIL branch_mis got=%h/%b exp=aaaaaaaabbbbbbb9/1", out_v, misalign); end
    idle(); step();
    tests++; if (out_v !== 64'hAAAAAAAA_BBBBBBBD || misalign !== 1'b0) begin
      fails++; $display("FAIL branch_mis_clr got=%h/%b exp=aaaaaaaabbbbbbbd/0", out_v, misalign); end
  endtask

  task automatic test_call_ret();
    do_reset();
    repeat (16) step();
    tests++; if (out_v !== 64'h40) begin fails++; $display("FAIL cr_pre got=%h exp=40", out_v); end
    call_en = 1; in_v = 64'h200;
    step();
    tests++; if (out_v !== 64'h200 || ras_empty !== 1'b0) begin
      fails++; $display("FAIL cr_call got=%h/%b exp=200/0", out_v, ras_empty); end
    idle(); step();
    tests++; if (out_v !== 64'h204) begin fails++; $display("FAIL cr_next got=%h exp=204", out_v); end
    ret_en = 1; step(); idle();
    tests++; if (out_v !== 64'h44 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL cr_ret got=%h/%b exp=44/1", out_v, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [63:0] exp_ret [5];
    exp_ret = '{64'h4004, 64'h3004, 64'h2004, 64'h1004, 64'h1008};
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      call_en = 1; in_v = 64'(i * 'h1000);
      step();
      tests++; if (out_v !== 64'(i * 'h1000) || ras_full !== (i >= 4) || ras_ovf !== (i == 5)) begin
        fails++; $display("FAIL ovf_call%0d got=%h full=%b ovf=%b", i, out_v, ras_full, ras_ovf); end
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      ret_en = 1; step();
      tests++; if (out_v !== exp_ret[i] || ras_unf !== (i == 4) || ras_empty !== (i >= 3)) begin
        fails++; $display("FAIL ovf_ret%0d got=%h unf=%b empty=%b exp=%h", i, out_v, ras_unf, ras_empty, exp_ret[i]); end
    end
    idle(); step();
    tests++; if (ras_ovf !== 1'b1 || ras_unf !== 1'b1 || ras_full !== 1'b0) begin
      fails++; $display("FAIL ovf_sticky got ovf=%b unf=%b full=%b exp=1/1/0", ras_ovf, ras_unf, ras_full); end
  endtask

  task automatic test_priority();
    do_reset();
    stall = 1; branch_en = 1; in_v = 64'h800;
    step(); step();
    tests++; if (out_v !== 64'h0) begin fails++; $display("FAIL stall_hold got=%h exp=0", out_v); end
    trap_en = 1; step();
    tests++; if (out_v !== 64'h100) begin fails++; $display("FAIL trap_over_stall got=%h exp=100", out_v); end
    idle(); call_en = 1; in_v = 64'h300; step();
    in_v = 64'h500; step();
    idle(); ret_en = 1; call_en = 1; in_v = 64'h900; step();
    tests++; if (out_v !== 64'h304 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      fails++; $display("FAIL ret_call got=%h empty=%b full=%b exp=304/0/0", out_v, ras_empty, ras_full); end
    idle(); stall = 1; ret_en = 1; step();
    tests++; if (out_v !== 64'h304) begin fails++; $display("FAIL stall_ret got=%h exp=304", out_v); end
    idle(); trap_en = 1; step();
    idle(); ret_en = 1; step(); idle();
    tests++; if (out_v !== 64'h104 || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
      fails++; $display("FAIL trap_keeps_ras got=%h empty=%b unf=%b exp=104/1/0", out_v, ras_empty, ras_unf); end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    branch_en = 1; in_v = 64'hFFFFFFFF_FFFFFFFC; step();
    idle(); step();
    tests++; if (out_v !== 64'h0) begin fails++; $display("FAIL wrap got=%h exp=0", out_v); end
    ret_en = 1; step();
    idle(); call_en = 1; in_v = 64'h600; step();
    in_v = 64'h702; step();
    tests++; if (out_v !== 64'h702 || misalign !== 1'b1 || ras_unf !== 1'b1 || ras_empty !== 1'b0) begin
      fails++; $display("FAIL pre_rst got=%h mis=%b unf=%b empty=%b", out_v, misalign, ras_unf, ras_empty); end
    in_v = 64'h800;
    #2; rst_n = 0; #1;
    tests++; if (out_v !== 64'h0 || {ras_empty, ras_full, ras_ovf, ras_unf, misalign} !== 5'b10000) begin
      fails++; $display("FAIL async_rst got=%h flags=%b exp=0/10000", out_v, {ras_empty, ras_full, ras_ovf, ras_unf, misalign}); end
    idle(); step();
    rst_n = 1; step();
    tests++; if (out_v !== 64'h4 || ras_empty !== 1'b1) begin
      fails++; $display("FAIL post_rst got=%h empty=%b exp=4/1", out_v, ras_empty); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_priority();
    test_wrap_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
